// File: rtl/cotm32_pkg.sv
// Shared types and sizing for the cotm32 memory arbiter slice.
// MEM_ARB_TIMEOUT_CYCLES is the default response timeout (used with MEM_ARB_TIMEOUT_EN).
package cotm32_pkg;
    localparam int XLEN                   = 32;
    localparam int BYTE_WIDTH             = 8;
    localparam int STRB_W                 = XLEN / BYTE_WIDTH;
    localparam int MEM_ARB_TIMEOUT_CYCLES = 64;

    typedef enum logic {
        ARB_OWNER_INST = 1'b0,
        ARB_OWNER_DATA = 1'b1
    } arb_owner_t;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_WAIT_RSP = 2'd1,
        ARB_DRAIN    = 2'd2
    } arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, LSU and unified-memory buses around mem_arbiter.
// master: the arbiter side; slave: requesters plus memory.
interface mem_arbiter_if;
    import cotm32_pkg::*;

    logic              inst_req;
    logic [XLEN-1:0]   inst_addr;
    logic              inst_gnt;
    logic              inst_rvalid;
    logic [XLEN-1:0]   inst_rdata;
    logic              inst_fault;

    logic              data_req;
    logic              data_we;
    logic [XLEN-1:0]   data_addr;
    logic [XLEN-1:0]   data_wdata;
    logic [STRB_W-1:0] data_wstrb;
    logic              data_gnt;
    logic              data_rvalid;
    logic [XLEN-1:0]   data_rdata;
    logic              data_fault;

    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        input  inst_req, inst_addr,
        output inst_gnt, inst_rvalid, inst_rdata, inst_fault,
        input  data_req, data_we, data_addr, data_wdata, data_wstrb,
        output data_gnt, data_rvalid, data_rdata, data_fault,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_gnt, inst_rvalid, inst_rdata, inst_fault,
        output data_req, data_we, data_addr, data_wdata, data_wstrb,
        input  data_gnt, data_rvalid, data_rdata, data_fault,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_arb_timer.sv
// Response-timeout counter for mem_arbiter (instantiated under MEM_ARB_TIMEOUT_EN).
// o_expire is high while the count sits at TIMEOUT_CYCLES-1.
module mem_arb_timer
    import cotm32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_ARB_TIMEOUT_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire = (r_cnt == LAST);
endmodule

// File: rtl/mem_arbiter.sv
// Fetch/LSU arbiter onto one memory port, one transaction outstanding, alternating ties.
// Optional response timeout with access fault: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import cotm32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_ARB_TIMEOUT_CYCLES
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    mem_arbiter_if.master io_bus
);
    arb_state_t r_state;
    arb_owner_t r_owner;
    arb_owner_t r_last_owner;
    logic       r_drop;

    logic       w_idle;
    logic       w_wait;
    logic       w_sel_data;
    arb_owner_t w_sel;
    logic       w_mem_req;
    logic       w_fire;
    logic       w_fwd_data;
    logic       w_kill;
    logic       w_rsp_ok;
    logic       w_tmo_hit;
    logic       w_tmo;
    logic       w_own_inst;
    logic       w_own_data;

    assign w_idle = (r_state == ARB_IDLE);
    assign w_wait = (r_state == ARB_WAIT_RSP);

    // Data wins alone, or on a tie when fetch went last.
    assign w_sel_data = io_bus.data_req
                      & (~io_bus.inst_req | (r_last_owner == ARB_OWNER_INST));
    assign w_sel      = w_sel_data ? ARB_OWNER_DATA : ARB_OWNER_INST;
    assign w_mem_req  = w_idle & (io_bus.inst_req | io_bus.data_req) & ~i_flush;
    assign w_fire     = w_mem_req & io_bus.mem_gnt;
    assign w_fwd_data = w_mem_req & w_sel_data;

    assign io_bus.mem_req   = w_mem_req;
    assign io_bus.mem_we    = w_fwd_data & io_bus.data_we;
    assign io_bus.mem_addr  = ~w_mem_req ? '0 :
                              w_sel_data ? io_bus.data_addr : io_bus.inst_addr;
    assign io_bus.mem_wdata = w_fwd_data ? io_bus.data_wdata : '0;
    assign io_bus.mem_wstrb = w_fwd_data ? io_bus.data_wstrb : '0;

    assign io_bus.inst_gnt = w_fire & ~w_sel_data;
    assign io_bus.data_gnt = w_fire & w_sel_data;

    assign w_kill   = r_drop | i_flush;
    assign w_rsp_ok = w_wait & io_bus.mem_rvalid & ~w_kill;

`ifdef MEM_ARB_TIMEOUT_EN
    logic w_expire;

    mem_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_fire),
        .i_enable(w_wait & ~io_bus.mem_rvalid),
        .o_expire(w_expire)
    );

    assign w_tmo_hit = w_wait & ~io_bus.mem_rvalid & w_expire;
`else
    assign w_tmo_hit = 1'b0;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    end
`endif

    assign w_tmo      = w_tmo_hit & ~w_kill;
    assign w_own_inst = (r_owner == ARB_OWNER_INST);
    assign w_own_data = (r_owner == ARB_OWNER_DATA);

    assign io_bus.inst_rvalid = (w_rsp_ok | w_tmo) & w_own_inst;
    assign io_bus.inst_rdata  = (w_rsp_ok & w_own_inst) ? io_bus.mem_rdata : '0;
    assign io_bus.inst_fault  = w_tmo & w_own_inst;
    assign io_bus.data_rvalid = (w_rsp_ok | w_tmo) & w_own_data;
    assign io_bus.data_rdata  = (w_rsp_ok & w_own_data) ? io_bus.mem_rdata : '0;
    assign io_bus.data_fault  = w_tmo & w_own_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ARB_IDLE;
            r_owner      <= ARB_OWNER_INST;
            r_last_owner <= ARB_OWNER_DATA;
            r_drop       <= 1'b0;
        end else begin
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_fire) begin
                        r_state      <= ARB_WAIT_RSP;
                        r_owner      <= w_sel;
                        r_last_owner <= w_sel;
                        r_drop       <= 1'b0;
                    end
                end
                ARB_WAIT_RSP: begin
                    if (i_flush) begin
                        r_drop <= 1'b1;
                    end
                    if (io_bus.mem_rvalid) begin
                        r_state <= ARB_IDLE;
                    end else if (w_tmo_hit) begin
                        r_state <= ARB_DRAIN;
                    end
                end
                ARB_DRAIN: begin
                    if (io_bus.mem_rvalid) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model.
// Build with MEM_ARB_TIMEOUT_EN to exercise the timeout/drain path.
module tb_mem_arbiter;
    import cotm32_pkg::*;

    localparam int TMO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_chk = 0;
    int   n_err = 0;

    mem_arbiter_if bus();

    mem_arbiter #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_flush(flush),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 waiting response, 2 draining.
    // Owners: 0 fetch, 1 data.
    int m_phase = 0;
    int m_owner = 0;
    int m_last  = 1;
    int m_age   = 0;
    bit m_drop  = 1'b0;
    bit m_on    = 1'b0;

    function automatic int winner();
        if (bus.inst_req && bus.data_req) return 1 - m_last;
        return bus.data_req ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        int w;
        bit rq, kill, dlv, tmo;
        if (m_on) begin
            w    = winner();
            rq   = (m_phase == 0) && (bus.inst_req || bus.data_req) && !flush;
            kill = m_drop || flush;
            dlv  = (m_phase == 1) && bus.mem_rvalid && !kill;
            tmo  = TMO_EN && (m_phase == 1) && !bus.mem_rvalid
                   && (m_age == TMO - 1) && !kill;
            chk("m_mem_req", bus.mem_req, rq);
            chk("m_mem_addr", bus.mem_addr,
                !rq ? 0 : (w == 1 ? bus.data_addr : bus.inst_addr));
            chk("m_mem_we", bus.mem_we, rq && w == 1 && bus.data_we);
            chk("m_mem_wdata", bus.mem_wdata,
                (rq && w == 1) ? bus.data_wdata : 0);
            chk("m_mem_wstrb", bus.mem_wstrb,
                (rq && w == 1) ? bus.data_wstrb : 0);
            chk("m_inst_gnt", bus.inst_gnt, rq && bus.mem_gnt && w == 0);
            chk("m_data_gnt", bus.data_gnt, rq && bus.mem_gnt && w == 1);
            chk("m_inst_rvalid", bus.inst_rvalid, (dlv || tmo) && m_owner == 0);
            chk("m_data_rvalid", bus.data_rvalid, (dlv || tmo) && m_owner == 1);
            chk("m_inst_rdata", bus.inst_rdata,
                (dlv && m_owner == 0) ? bus.mem_rdata : 0);
            chk("m_data_rdata", bus.data_rdata,
                (dlv && m_owner == 1) ? bus.mem_rdata : 0);
            chk("m_inst_fault", bus.inst_fault, tmo && m_owner == 0);
            chk("m_data_fault", bus.data_fault, tmo && m_owner == 1);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_on    = 1'b1;
            m_phase = 0;
            m_last  = 1;
            m_drop  = 1'b0;
            m_age   = 0;
        end else if (m_on) begin
            case (m_phase)
                0: begin
                    if ((bus.inst_req || bus.data_req) && !flush && bus.mem_gnt) begin
                        m_owner = winner();
                        m_last  = m_owner;
                        m_drop  = 1'b0;
                        m_age   = 0;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (flush) m_drop = 1'b1;
                    if (bus.mem_rvalid) m_phase = 0;
                    else if (TMO_EN && m_age == TMO - 1) m_phase = 2;
                    else m_age++;
                end
                default: begin
                    if (bus.mem_rvalid) m_phase = 0;
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    int exp_own[4] = '{0, 1, 0, 1};

    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        bus.inst_req    = 1'b0;
        bus.inst_addr   = '0;
        bus.data_req    = 1'b0;
        bus.data_we     = 1'b0;
        bus.data_addr   = '0;
        bus.data_wdata  = '0;
        bus.data_wstrb  = '0;
        bus.mem_gnt     = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
        step();
        step();
        rst = 1'b0;
        mid();
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_outs", {bus.inst_gnt, bus.data_gnt, bus.inst_rvalid,
            bus.data_rvalid, bus.inst_fault, bus.data_fault}, 0);

        // single fetch
        step();
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h100;
        bus.mem_gnt   = 1'b1;
        mid();
        chk("t1_inst_gnt", bus.inst_gnt, 1);
        chk("t1_mem_addr", bus.mem_addr, 32'h100);
        chk("t1_mem_we", bus.mem_we, 0);
        step();
        bus.inst_req   = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0050_0093;
        mid();
        chk("t1_inst_rvalid", bus.inst_rvalid, 1);
        chk("t1_inst_rdata", bus.inst_rdata, 32'h0050_0093);
        chk("t1_data_rvalid", bus.data_rvalid, 0);
        step();
        bus.mem_rvalid = 1'b0;

        // alternating grants after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.data_we    = 1'b1;
        bus.data_addr  = 32'h200;
        bus.data_wdata = 32'hdead_beef;
        bus.data_wstrb = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            bus.inst_req   = 1'b1;
            bus.data_req   = 1'b1;
            bus.inst_addr  = 32'h104 + 32'(k * 4);
            bus.mem_gnt    = 1'b1;
            bus.mem_rvalid = 1'b0;
            mid();
            chk("t2_inst_gnt", bus.inst_gnt, exp_own[k] == 0);
            chk("t2_data_gnt", bus.data_gnt, exp_own[k] == 1);
            chk("t2_mem_we", bus.mem_we, exp_own[k] == 1);
            chk("t2_mem_wstrb", bus.mem_wstrb, exp_own[k] == 1 ? 32'h3 : 32'h0);
            step();
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'h1000 + 32'(k);
            mid();
            chk("t2_rvalid",
                exp_own[k] == 1 ? bus.data_rvalid : bus.inst_rvalid, 1);
            step();
            bus.mem_rvalid = 1'b0;
        end
        bus.inst_req   = 1'b0;
        bus.data_req   = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_wdata = '0;
        bus.data_wstrb = '0;

        // memory stalls the grant for three cycles
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h300;
        bus.mem_gnt   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("t3_mem_addr", bus.mem_addr, 32'h300);
            chk("t3_data_gnt_lo", bus.data_gnt, 0);
            step();
        end
        bus.mem_gnt = 1'b1;
        mid();
        chk("t3_data_gnt", bus.data_gnt, 1);
        step();
        bus.data_req   = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h33;
        mid();
        chk("t3_data_rvalid", bus.data_rvalid, 1);
        chk("t3_data_rdata", bus.data_rdata, 32'h33);
        step();
        bus.mem_rvalid = 1'b0;

        // flush while waiting, response two cycles later
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h400;
        bus.mem_gnt   = 1'b1;
        mid();
        chk("t4_inst_gnt", bus.inst_gnt, 1);
        step();
        bus.inst_req = 1'b0;
        bus.mem_gnt  = 1'b0;
        flush        = 1'b1;
        mid();
        chk("t4_mem_req", bus.mem_req, 0);
        step();
        flush = 1'b0;
        step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'habc;
        bus.data_req   = 1'b1;
        bus.data_addr  = 32'h500;
        bus.mem_gnt    = 1'b1;
        mid();
        chk("t4_inst_rvalid", bus.inst_rvalid, 0);
        chk("t4_no_same_gnt", bus.data_gnt, 0);
        step();
        bus.mem_rvalid = 1'b0;
        mid();
        chk("t4_next_gnt", bus.data_gnt, 1);
        step();
        bus.data_req   = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h55;
        mid();
        chk("t4_data_rvalid", bus.data_rvalid, 1);
        step();
        bus.mem_rvalid = 1'b0;

        // flush coincident with the response
        bus.inst_req = 1'b1;
        bus.mem_gnt  = 1'b1;
        step();
        bus.inst_req   = 1'b0;
        bus.mem_gnt    = 1'b0;
        flush          = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h77;
        mid();
        chk("t4b_inst_rvalid", bus.inst_rvalid, 0);
        step();
        flush          = 1'b0;
        bus.mem_rvalid = 1'b0;

        // flush in idle blocks the grant
        bus.inst_req = 1'b1;
        bus.mem_gnt  = 1'b1;
        flush        = 1'b1;
        mid();
        chk("t4c_mem_req", bus.mem_req, 0);
        chk("t4c_inst_gnt", bus.inst_gnt, 0);
        step();
        flush = 1'b0;
        mid();
        chk("t4c_inst_gnt2", bus.inst_gnt, 1);
        step();
        bus.inst_req   = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        step();
        bus.mem_rvalid = 1'b0;

        // response timeout
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h600;
        bus.mem_gnt   = 1'b1;
        mid();
        chk("t5_data_gnt", bus.data_gnt, 1);
        step();
        bus.data_req = 1'b0;
        bus.mem_gnt  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            mid();
            if (k < 4) begin
                chk("t5_early_rvalid", bus.data_rvalid, 0);
            end else begin
                chk("t5_tmo_rvalid", bus.data_rvalid, 1);
                chk("t5_tmo_fault", bus.data_fault, 1);
                chk("t5_tmo_rdata", bus.data_rdata, 0);
            end
            step();
        end
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h700;
        bus.mem_gnt   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mid();
            chk("t5_drain_gnt", bus.inst_gnt, 0);
            step();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h66;
        mid();
        chk("t5_late_gnt", bus.inst_gnt, 0);
        chk("t5_late_rv", {bus.inst_rvalid, bus.data_rvalid}, 0);
        step();
        bus.mem_rvalid = 1'b0;
        mid();
        chk("t5_after_gnt", bus.inst_gnt, 1);
        step();
        bus.inst_req   = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        mid();
        chk("t5_after_rvalid", bus.inst_rvalid, 1);
        step();
        bus.mem_rvalid = 1'b0;
`else
        for (int k = 0; k < 6; k++) begin
            mid();
            chk("t5_wait_rvalid", bus.data_rvalid, 0);
            chk("t5_wait_fault", bus.data_fault, 0);
            step();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h66;
        mid();
        chk("t5_slow_rvalid", bus.data_rvalid, 1);
        chk("t5_slow_fault", bus.data_fault, 0);
        step();
        bus.mem_rvalid = 1'b0;
`endif

        // reset mid-transaction
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h800;
        bus.mem_gnt   = 1'b1;
        mid();
        chk("t6_data_gnt", bus.data_gnt, 1);
        step();
        bus.data_req = 1'b0;
        bus.mem_gnt  = 1'b0;
        rst          = 1'b1;
        step();
        rst            = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h99;
        mid();
        chk("t6_outs", {bus.mem_req, bus.mem_we, bus.inst_gnt, bus.data_gnt,
            bus.inst_rvalid, bus.data_rvalid, bus.inst_fault, bus.data_fault}, 0);
        chk("t6_mem_addr", bus.mem_addr, 0);
        step();
        bus.mem_rvalid = 1'b0;
        bus.inst_req   = 1'b1;
        bus.data_req   = 1'b1;
        bus.mem_gnt    = 1'b1;
        mid();
        chk("t6_tie_inst", bus.inst_gnt, 1);
        chk("t6_tie_data", bus.data_gnt, 0);
        step();
        bus.inst_req   = 1'b0;
        bus.data_req   = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234;
        mid();
        chk("t6_inst_rvalid", bus.inst_rvalid, 1);
        step();
        bus.mem_rvalid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
